// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, sequencer states, datapath mux/ALU encodings.
// Pure declarations, no logic; used by both the single-cycle decoder and the multicycle sequencer.
// No flow control of its own.
package cpu_pkg;

    localparam int OP_W    = 4;
    localparam int ALUOP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ST   = 4'h3;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h4;
    localparam logic [OP_W-1:0] OP_INC  = 4'h5;
    localparam logic [OP_W-1:0] OP_NEG  = 4'h6;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h7;
    localparam logic [OP_W-1:0] OP_J    = 4'h8;
    localparam logic [OP_W-1:0] OP_BRZ  = 4'h9;
    localparam logic [OP_W-1:0] OP_JM   = 4'hA;
    localparam logic [OP_W-1:0] OP_BRN  = 4'hB;
    localparam logic [OP_W-1:0] OP_LD   = 4'hE;
    localparam logic [OP_W-1:0] OP_SVPC = 4'hF;

    localparam logic [1:0] PC_SRC_INC = 2'd0;
    localparam logic [1:0] PC_SRC_RS  = 2'd1;
    localparam logic [1:0] PC_SRC_MEM = 2'd2;

    localparam logic [ALUOP_W-1:0] ALU_PASS = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_ADDK = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_NEG  = 3'd2;
    localparam logic [ALUOP_W-1:0] ALU_ADD  = 3'd3;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // JM reads memory for its target, so it is a memory-class op
    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_BRANCH  = 3'd2,
        CLS_MEM     = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    typedef struct packed {
        op_class_t            cls;
        logic [ALUOP_W-1:0]   alu_op;
        logic                 alu_src;
        logic                 alu_flags;
    } op_info_t;

endpackage

// File: rtl/op_classify.sv
// Opcode classifier: class, ALU operation, ALU B-source and flag-update qualifier.
// Purely combinational, zero latency.
// No flow control.
module op_classify
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output op_info_t        info
);

    always_comb begin
        info.cls       = CLS_ILLEGAL;
        info.alu_op    = ALU_PASS;
        info.alu_src   = 1'b0;
        info.alu_flags = 1'b0;
        case (op)
            OP_NOP:  info.cls = CLS_NOP;
            OP_ST,
            OP_LD,
            OP_JM:   info.cls = CLS_MEM;
            OP_J:    info.cls = CLS_JUMP;
            OP_BRZ,
            OP_BRN:  info.cls = CLS_BRANCH;
            OP_ADD: begin
                info.cls       = CLS_ALU;
                info.alu_op    = ALU_ADD;
                info.alu_flags = 1'b1;
            end
            OP_INC: begin
                info.cls       = CLS_ALU;
                info.alu_op    = ALU_ADDK;
                info.alu_src   = 1'b1;
                info.alu_flags = 1'b1;
            end
            OP_NEG: begin
                info.cls       = CLS_ALU;
                info.alu_op    = ALU_NEG;
                info.alu_flags = 1'b1;
            end
            OP_SUB: begin
                info.cls       = CLS_ALU;
                info.alu_op    = ALU_SUB;
                info.alu_flags = 1'b1;
            end
            // SVPC saves PC+1 into a register and leaves z/n untouched
            OP_SVPC: begin
                info.cls     = CLS_ALU;
                info.alu_op  = ALU_ADDK;
                info.alu_src = 1'b1;
            end
            default: info.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Latency 2 (J/NOP), 3 (branch), 4 (ALU/SVPC/ST/JM), 5 (LD) cycles plus memory wait.
// Memory req held until ack; run=0 parks in FETCH once no fetch is outstanding.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int OPW    = OP_W,
    parameter int ALUOPW = ALUOP_W
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [31:0]       ir,
    input  logic              z,
    input  logic              n,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic              addr_sel,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_src,
    output logic              rf_we,
    output logic              rf_wsel,
    output logic              alu_src,
    output logic [ALUOPW-1:0] alu_op,
    output logic              flag_we,
    output logic              illegal,
    output logic              busy
);

    logic [OPW-1:0] op;
    logic           ir_unused;
    op_info_t       info;
    state_t         state, state_nxt;
    logic           armed;
    logic           req_pend;
    logic           req_live;
    logic           ack;

    assign op        = ir[31 -: OPW];
    assign ir_unused = ^ir[31-OPW:0];

    op_classify u_classify (
        .op   (op),
        .info (info)
    );

    // armed keeps every output low for the first cycle out of reset, so an ack
    // left over from before reset cannot be taken as a fetch completion
    assign req_live = armed && ((state == ST_FETCH && (run || req_pend)) || state == ST_MEM);
    assign ack      = req_live && mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            armed    <= 1'b0;
            req_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            armed    <= 1'b1;
            req_pend <= req_live && !mem_ack;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  if (ack) state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (info.cls)
                    CLS_ALU, CLS_BRANCH, CLS_MEM: state_nxt = ST_EXEC;
                    default:                      state_nxt = ST_FETCH;
                endcase
            end
            ST_EXEC: begin
                case (info.cls)
                    CLS_ALU: state_nxt = ST_WB;
                    CLS_MEM: state_nxt = ST_MEM;
                    default: state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM:    if (ack) state_nxt = (op == OP_LD) ? ST_WB : ST_FETCH;
            ST_WB:     state_nxt = ST_FETCH;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        mem_req  = req_live;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = PC_SRC_INC;
        rf_we    = 1'b0;
        rf_wsel  = 1'b0;
        alu_src  = 1'b0;
        alu_op   = ALU_PASS;
        flag_we  = 1'b0;
        illegal  = 1'b0;
        busy     = (state != ST_FETCH) || req_live;
        case (state)
            ST_FETCH: begin
                if (ack) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            ST_DECODE: begin
                if (info.cls == CLS_JUMP) begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_RS;
                end
                illegal = (info.cls == CLS_ILLEGAL);
            end
            ST_EXEC: begin
                case (info.cls)
                    CLS_ALU: begin
                        alu_op  = info.alu_op;
                        alu_src = info.alu_src;
                        flag_we = info.alu_flags;
                    end
                    CLS_BRANCH: begin
                        pc_src = PC_SRC_RS;
                        pc_we  = (op == OP_BRN) ? n : z;
                    end
                    CLS_MEM: addr_sel = 1'b1;
                    default: ;
                endcase
            end
            ST_MEM: begin
                addr_sel = 1'b1;
                mem_we   = (op == OP_ST);
                if (ack && op == OP_JM) begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_MEM;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                rf_wsel = (op == OP_LD);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one step per cycle, inputs driven at the
// falling edge, all control outputs compared as one packed word 1 ns later.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] ir;
    logic        z;
    logic        n;
    logic        mem_ack;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we;
    logic [1:0]  pc_src;
    logic        rf_we, rf_wsel, alu_src;
    logic [2:0]  alu_op;
    logic        flag_we, illegal, busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .ir       (ir),
        .z        (z),
        .n        (n),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .addr_sel (addr_sel),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .pc_src   (pc_src),
        .rf_we    (rf_we),
        .rf_wsel  (rf_wsel),
        .alu_src  (alu_src),
        .alu_op   (alu_op),
        .flag_we  (flag_we),
        .illegal  (illegal),
        .busy     (busy)
    );

    // {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, rf_we, rf_wsel, alu_src, alu_op, flag_we, illegal, busy}
    localparam logic [15:0] REQ    = 16'h8000;
    localparam logic [15:0] MWE    = 16'h4000;
    localparam logic [15:0] ASEL   = 16'h2000;
    localparam logic [15:0] IRWE   = 16'h1000;
    localparam logic [15:0] PCWE   = 16'h0800;
    localparam logic [15:0] PS_MEM = 16'h0400;
    localparam logic [15:0] PS_RS  = 16'h0200;
    localparam logic [15:0] RFWE   = 16'h0100;
    localparam logic [15:0] WSEL   = 16'h0080;
    localparam logic [15:0] ASRC   = 16'h0040;
    localparam logic [15:0] AOP1   = 16'h0008;
    localparam logic [15:0] AOP2   = 16'h0010;
    localparam logic [15:0] AOP3   = 16'h0018;
    localparam logic [15:0] AOP4   = 16'h0020;
    localparam logic [15:0] FWE    = 16'h0004;
    localparam logic [15:0] ILL    = 16'h0002;
    localparam logic [15:0] BUSY   = 16'h0001;
    localparam logic [15:0] F_ACK  = REQ | IRWE | PCWE | BUSY;
    localparam logic [15:0] IDLE   = 16'h0000;

    logic [15:0] obs;
    assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, rf_we, rf_wsel,
                  alu_src, alu_op, flag_we, illegal, busy};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // called at a falling edge; drives inputs, checks, then advances one cycle
    task automatic step(input string tag, input logic r, input logic a,
                        input logic zz, input logic nn, input logic [15:0] exp);
        run     = r;
        mem_ack = a;
        z       = zz;
        n       = nn;
        #1 chk(tag, obs, exp);
        @(negedge clk);
    endtask

    task automatic alu_instr(input string tag, input logic [3:0] op, input logic [15:0] e_exec);
        ir = {op, 28'h0123456};
        step({tag, "_f"},  1'b1, 1'b1, 1'b0, 1'b0, F_ACK);
        step({tag, "_d"},  1'b1, 1'b0, 1'b0, 1'b0, BUSY);
        step({tag, "_e"},  1'b1, 1'b0, 1'b0, 1'b0, e_exec | BUSY);
        step({tag, "_wb"}, 1'b1, 1'b0, 1'b0, 1'b0, RFWE | BUSY);
    endtask

    task automatic branch(input string tag, input logic [3:0] op, input logic zz,
                          input logic nn, input logic [15:0] e_exec);
        ir = {op, 28'h0000010};
        step({tag, "_f"}, 1'b1, 1'b1, zz, nn, F_ACK);
        step({tag, "_d"}, 1'b1, 1'b0, zz, nn, BUSY);
        step({tag, "_e"}, 1'b1, 1'b0, zz, nn, e_exec | BUSY);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        run     = 1'b1;
        mem_ack = 1'b0;
        z       = 1'b0;
        n       = 1'b0;
        ir      = 32'h4000_0000;
        repeat (2) @(negedge clk);
        #1 chk("reset", obs, IDLE);

        // reset asserted in the middle of a waiting fetch
        @(negedge clk);
        rst_n = 1'b1;
        step("arm",    1'b1, 1'b0, 1'b0, 1'b0, IDLE);
        step("f_wait", 1'b1, 1'b0, 1'b0, 1'b0, REQ | BUSY);
        rst_n = 1'b0;
        #1 chk("rst_mid", obs, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        step("stale_ack", 1'b1, 1'b1, 1'b0, 1'b0, IDLE);

        // ALU class, zero-wait fetch
        alu_instr("add",  4'h4, AOP3 | FWE);
        alu_instr("inc",  4'h5, ASRC | AOP1 | FWE);
        alu_instr("neg",  4'h6, AOP2 | FWE);
        alu_instr("sub",  4'h7, AOP4 | FWE);
        alu_instr("svpc", 4'hF, ASRC | AOP1);

        // LD with a 3-cycle data wait
        ir = 32'hE000_0004;
        step("ld_f",  1'b1, 1'b1, 1'b0, 1'b0, F_ACK);
        step("ld_d",  1'b1, 1'b0, 1'b0, 1'b0, BUSY);
        step("ld_e",  1'b1, 1'b0, 1'b0, 1'b0, ASEL | BUSY);
        step("ld_m1", 1'b1, 1'b0, 1'b0, 1'b0, REQ | ASEL | BUSY);
        step("ld_m2", 1'b1, 1'b0, 1'b0, 1'b0, REQ | ASEL | BUSY);
        step("ld_m3", 1'b1, 1'b1, 1'b0, 1'b0, REQ | ASEL | BUSY);
        step("ld_wb", 1'b1, 1'b0, 1'b0, 1'b0, RFWE | WSEL | BUSY);

        // ST, zero-wait data write
        ir = 32'h3000_0008;
        step("st_f",  1'b1, 1'b1, 1'b0, 1'b0, F_ACK);
        step("st_d",  1'b1, 1'b0, 1'b0, 1'b0, BUSY);
        step("st_e",  1'b1, 1'b0, 1'b0, 1'b0, ASEL | BUSY);
        step("st_m",  1'b1, 1'b1, 1'b0, 1'b0, REQ | MWE | ASEL | BUSY);

        // conditional branches, opposite flag set to catch a swapped select
        branch("brz_t", 4'h9, 1'b1, 1'b0, PCWE | PS_RS);
        branch("brz_n", 4'h9, 1'b0, 1'b1, PS_RS);
        branch("brn_t", 4'hB, 1'b0, 1'b1, PCWE | PS_RS);
        branch("brn_n", 4'hB, 1'b1, 1'b0, PS_RS);

        // JM: memory-indirect jump with one wait cycle
        ir = 32'hA000_000C;
        step("jm_f",  1'b1, 1'b1, 1'b0, 1'b0, F_ACK);
        step("jm_d",  1'b1, 1'b0, 1'b0, 1'b0, BUSY);
        step("jm_e",  1'b1, 1'b0, 1'b0, 1'b0, ASEL | BUSY);
        step("jm_m1", 1'b1, 1'b0, 1'b0, 1'b0, REQ | ASEL | BUSY);
        step("jm_m2", 1'b1, 1'b1, 1'b0, 1'b0, REQ | ASEL | PCWE | PS_MEM | BUSY);

        // J resolves in DECODE
        ir = 32'h8000_0000;
        step("j_f",   1'b1, 1'b1, 1'b0, 1'b0, F_ACK);
        step("j_d",   1'b1, 1'b0, 1'b0, 1'b0, PCWE | PS_RS | BUSY);

        // run drops while a fetch is outstanding: fetch still completes
        ir = 32'h0000_0000;
        step("nop_w",    1'b1, 1'b0, 1'b0, 1'b0, REQ | BUSY);
        step("nop_hold", 1'b0, 1'b0, 1'b0, 1'b0, REQ | BUSY);
        step("nop_f",    1'b0, 1'b1, 1'b0, 1'b0, F_ACK);
        step("nop_d",    1'b0, 1'b0, 1'b0, 1'b0, BUSY);
        step("park",     1'b0, 1'b0, 1'b0, 1'b0, IDLE);

        // illegal opcode pulses once, then parked with a stray ack ignored
        ir = 32'hC000_0000;
        step("ill_f",    1'b1, 1'b1, 1'b0, 1'b0, F_ACK);
        step("ill_d",    1'b0, 1'b0, 1'b0, 1'b0, ILL | BUSY);
        step("ill_idle", 1'b0, 1'b1, 1'b0, 1'b0, IDLE);
        step("ill_idle2",1'b0, 1'b0, 1'b0, 1'b0, IDLE);
        step("restart",  1'b1, 1'b0, 1'b0, 1'b0, REQ | BUSY);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle sequencer for the 4-bit-opcode CPU datapath. It replaces the single-cycle combinational decode with an FSM that walks each instruction through FETCH/DECODE/EXEC/MEM/WB. It talks to a shared instruction/data memory through a req/ack handshake with variable latency. It drives PC, IR, register-file, ALU and flag enables cycle by cycle.

Parameters:
OPW, 4, opcode width (inst[31:28])
ALUOPW, 3, ALU operation select width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  when 0, FSM parks in FETCH and issues no new request
ir  in  32  instruction register contents; opcode = ir[31:28]
z  in  1  zero flag (registered in datapath)
n  in  1  negative flag (registered in datapath)
mem_ack  in  1  memory completed current request (1-cycle pulse)
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write qualifier for mem_req
addr_sel  out  1  0 = PC drives address, 1 = register/ALU result
ir_we  out  1  load IR from mem_rdata
pc_we  out  1  load PC
pc_src  out  2  0 = PC+1, 1 = rs register, 2 = mem_rdata
rf_we  out  1  register-file write enable
rf_wsel  out  1  0 = ALU result, 1 = mem_rdata
alu_src  out  1  0 = rt, 1 = PC (SVPC) / constant (INC)
alu_op  out  3  0 pass, 1 add-const/pc, 2 neg, 4 sub, 3 add
flag_we  out  1  latch z/n from ALU result
illegal  out  1  1-cycle pulse on undefined opcode
busy  out  1  1 whenever state != FETCH or mem_req == 1

Behaviour:
- Opcodes: NOP 0x0, ST 0x3, ADD 0x4, INC 0x5, NEG 0x6, SUB 0x7, J 0x8, BRZ 0x9, JM 0xA, BRN 0xB, LD 0xE, SVPC 0xF. 0x1, 0x2, 0xC and 0xD are illegal.
- States: FETCH, DECODE, EXEC, MEM, WB. Encoding is in the package.
- Reset (async, rst_n=0): state=FETCH, all outputs 0, no request outstanding. Applies mid-transaction; a late mem_ack after reset is ignored.
- FETCH: if run=1, assert mem_req=1, mem_we=0, addr_sel=0. Hold all three until mem_ack.
  - On the ack cycle: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
  - If run=0 and no request is outstanding, stay idle. An outstanding fetch completes regardless of run.
- DECODE (1 cycle):
  - J: pc_we=1, pc_src=1 -> FETCH.
  - NOP: -> FETCH.
  - Illegal: illegal=1 -> FETCH, executed as NOP.
  - All others -> EXEC.
- EXEC (1 cycle):
  - ALU ops and SVPC: alu_op/alu_src per opcode, flag_we=1 (not for SVPC) -> WB.
  - BRZ: pc_we=z, pc_src=1 -> FETCH.
  - BRN: pc_we=n, pc_src=1 -> FETCH.
  - z and n are sampled in this cycle; flags written in the same cycle are not visible.
  - LD, ST, JM: addr_sel=1 -> MEM.
- MEM: mem_req=1, addr_sel=1, mem_we=1 only for ST. Held until mem_ack.
  - On ack, ST -> FETCH.
  - On ack, LD -> WB.
  - On ack, JM: pc_we=1, pc_src=2 -> FETCH.
- WB (1 cycle): rf_we=1, rf_wsel=1 for LD, else 0 -> FETCH.
- Latency in cycles, excluding memory wait beyond 1 cycle each:
  - J/NOP: 2
  - BRZ/BRN: 3
  - ALU/SVPC: 4
  - ST/JM: 4
  - LD: 5
- mem_ack with mem_req=0 is ignored. mem_ack in the same cycle req rises is legal (zero-wait memory).
- Control outputs are Moore/Mealy on state+opcode+ack only. No combinational path from mem_ack to mem_req.
- At most one of pc_we, rf_we, mem_we is asserted in any cycle, except FETCH ack (ir_we+pc_we).

Decomposition:
- Package cpu_pkg: opcode localparams (OP_NOP..OP_SVPC), state encoding, pc_src/alu_op constants. The existing single-cycle decoder shares these.
- One sub-module, op_classify: combinational opcode -> class (alu, branch, mem, jump, illegal), alu_op, alu_src.
- The FSM stays in multicycle_ctrl.

Test Plan:
- Reset mid-fetch: rst_n=0 while mem_req=1 -> mem_req=0 immediately. After release with run=1, the first fetch restarts; a stale ack 1 cycle later produces no ir_we.
- ADD (ir=0x4xxxxxxx), zero-wait ack -> ir_we at cycle 1, then EXEC alu_op=3 flag_we=1, then WB rf_we=1 rf_wsel=0, then FETCH. 4 cycles total.
- LD (0xE...), 3-cycle wait on data ack -> mem_req held 3 cycles with addr_sel=1 mem_we=0, then WB rf_wsel=1. ST (0x3...) -> mem_we=1, no rf_we.
- BRZ with z=1 / z=0 and BRN with n=1 / n=0 -> pc_we=1 pc_src=1 only in the taken cases, in EXEC.
- JM (0xA...) -> MEM read, then pc_we=1 pc_src=2 on ack, no rf_we. J (0x8...) -> pc_we in DECODE.
- Illegal 0xC and run=0 -> illegal pulses exactly once, no write enables asserted. With run=0 in FETCH, mem_req stays 0 and busy=0.
